// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared types and default constants for the frame-buffer pixel writer.
//   pixel_t     : one queued BRAM write (linear word address + {r,g,b})
//   fbw_state_t : writer FSM states
//   H_RES_DEF / V_RES_DEF : default frame geometry
//   PIX_ADDR_W  : address width stored per FIFO entry
// -----------------------------------------------------------------------------
package pixel_pkg;

  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 180;
  localparam int PIX_ADDR_W = 16;

  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [11:0]           rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous FIFO of pixel_t entries. Push and pop in the same cycle are legal
// even when full (the head is read out before the slot is overwritten).
// Ports:
//   clk_in, rst_in     clock, synchronous active-low reset
//   flush_in           empties the FIFO (pointer reset)
//   push_in, push_data_in  write one entry
//   pop_in             retire the head entry
//   head_out           current head (valid only when !empty_out)
//   full_out, empty_out status
// -----------------------------------------------------------------------------
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   flush_in,
  input  logic   push_in,
  input  pixel_t push_data_in,
  input  logic   pop_in,
  output pixel_t head_out,
  output logic   full_out,
  output logic   empty_out
);

  localparam int PTR_W = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  pixel_t         mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty_out = (wr_ptr == rd_ptr);
  assign full_out  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_out  = mem[rd_ptr[PTR_W-1:0]];

  assign do_pop  = pop_in && !empty_out;
  assign do_push = push_in && (!full_out || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which entries
  // are meaningful, and leaving the array reset-free lets it map to LUT-RAM.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data_in;
  end

endmodule

// File: rtl/framebuffer_pixel_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_pixel_writer
// Sink for the shading-pipeline pixel stream. In-range beats are converted to a
// linear address (y*H_RES + x), queued in a small FIFO, and written to the
// frame-buffer BRAM whenever the write port is granted. Counts writes and
// pulses frame_done_out when a full frame has been stored.
// Ports:
//   clk_in, rst_in          clock, synchronous active-low reset
//   frame_start_in          arms the writer (IDLE only)
//   x_in, y_in, r/g/b_in, rgb_valid_in  incoming pixel beat (no backpressure)
//   fb_ready_in             BRAM write port granted this cycle
//   fb_addr_out, fb_data_out, fb_we_out  BRAM write port
//   frame_done_out          one-cycle pulse per completed frame
//   busy_out                high while collecting a frame
//   overflow_out, oob_out   sticky drop flags (FIFO full / coordinate range)
// Optional build macro FB_DOUBLE_BUFFER_EN adds fb_bank_out / disp_bank_out,
// swapping banks at every completed frame.
// -----------------------------------------------------------------------------
module framebuffer_pixel_writer
  import pixel_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = PIX_ADDR_W   // must not exceed PIX_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [10:0]       x_in,
  input  logic [10:0]       y_in,
  input  logic [3:0]        r_in,
  input  logic [3:0]        g_in,
  input  logic [3:0]        b_in,
  input  logic              rgb_valid_in,
  input  logic              fb_ready_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [11:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic              overflow_out,
  output logic              oob_out
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  output logic              fb_bank_out,
  output logic              disp_bank_out
`endif
);

  localparam int FRAME_PIX = H_RES * V_RES;

  fbw_state_t        state;
  logic [ADDR_W-1:0] pix_count;
  pixel_t            hold_q;
  pixel_t            push_pix;
  pixel_t            head_pix;
  pixel_t            out_pix;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_run;
  logic              in_range;
  logic              beat_ok;
  logic              push;
  logic              pop;
  logic              flush;
  logic              last_write;
  logic [21:0]       lin_addr;

  assign in_run   = (state == RUN);
  assign in_range = (int'(x_in) < H_RES) && (int'(y_in) < V_RES);
  assign beat_ok  = in_run && rgb_valid_in && in_range;

  // 22 bits hold 2047*H_RES + 2047 for any H_RES up to 2048; the stored
  // address is this value truncated.
  assign lin_addr = 22'(y_in) * 22'(H_RES) + 22'(x_in);

  assign push_pix.addr = PIX_ADDR_W'(ADDR_W'(lin_addr));
  assign push_pix.rgb  = {r_in, g_in, b_in};

  assign pop   = !fifo_empty && fb_ready_in;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push  = beat_ok && (!fifo_full || pop);
  // Leftover entries from a previous frame are discarded on the next arm.
  assign flush = (state == IDLE) && frame_start_in;

  assign last_write = in_run && pop && (pix_count == ADDR_W'(FRAME_PIX - 1));

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush),
    .push_in     (push),
    .push_data_in(push_pix),
    .pop_in      (pop),
    .head_out    (head_pix),
    .full_out    (fifo_full),
    .empty_out   (fifo_empty)
  );

  // The BRAM port shows the head while data is queued and otherwise keeps the
  // last head it presented, so the bus does not wander when idle.
  assign out_pix     = fifo_empty ? hold_q : head_pix;
  assign fb_addr_out = ADDR_W'(out_pix.addr);
  assign fb_data_out = out_pix.rgb;
  assign fb_we_out   = pop;

  assign frame_done_out = (state == DONE);
  assign busy_out       = in_run;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      pix_count    <= '0;
      hold_q       <= '0;
      overflow_out <= 1'b0;
      oob_out      <= 1'b0;
    end else begin
      if (!fifo_empty) hold_q <= head_pix;

      if (in_run && rgb_valid_in && !in_range) oob_out <= 1'b1;
      if (beat_ok && fifo_full && !pop)        overflow_out <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start_in) begin
            state     <= RUN;
            pix_count <= '0;
          end
        end
        RUN: begin
          if (last_write) begin
            state     <= DONE;
            pix_count <= '0;
          end else if (pop) begin
            pix_count <= pix_count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in)             fb_bank_out <= 1'b0;
    else if (state == DONE)  fb_bank_out <= ~fb_bank_out;
  end

  assign disp_bank_out = ~fb_bank_out;
`endif

endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_pixel_writer
// Scoreboard bench: stimulus pushes expected BRAM writes into a queue, a
// negedge monitor pops and compares each write the DUT performs. Geometry is
// shrunk to 8x4 so complete frames are short. Build with FB_DOUBLE_BUFFER_EN
// defined to also exercise the bank outputs.
// -----------------------------------------------------------------------------
module tb_framebuffer_pixel_writer;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int DEP  = 16;
  localparam int AW   = 16;
  localparam int FPIX = H * V;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   rgb;
    int            cyc;    // exact write cycle, or -1 when not timed
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic [10:0]   x_in = '0;
  logic [10:0]   y_in = '0;
  logic [3:0]    r_in = '0;
  logic [3:0]    g_in = '0;
  logic [3:0]    b_in = '0;
  logic          rgb_valid_in = 1'b0;
  logic          fb_ready_in = 1'b0;
  logic [AW-1:0] fb_addr_out;
  logic [11:0]   fb_data_out;
  logic          fb_we_out;
  logic          frame_done_out;
  logic          busy_out;
  logic          overflow_out;
  logic          oob_out;
`ifdef FB_DOUBLE_BUFFER_EN
  logic          fb_bank_out;
  logic          disp_bank_out;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  framebuffer_pixel_writer #(
    .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEP), .ADDR_W(AW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .frame_start_in(frame_start_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .r_in          (r_in),
    .g_in          (g_in),
    .b_in          (b_in),
    .rgb_valid_in  (rgb_valid_in),
    .fb_ready_in   (fb_ready_in),
    .fb_addr_out   (fb_addr_out),
    .fb_data_out   (fb_data_out),
    .fb_we_out     (fb_we_out),
    .frame_done_out(frame_done_out),
    .busy_out      (busy_out),
    .overflow_out  (overflow_out),
    .oob_out       (oob_out)
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    .fb_bank_out   (fb_bank_out),
    .disp_bank_out (disp_bank_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected entry.
  always @(negedge clk_in) begin
    if (frame_done_out) done_cnt++;
    if (fb_we_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", fb_addr_out, fb_data_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(fb_addr_out), 32'(e.addr));
        check("wr_data", 32'(fb_data_out), 32'(e.rgb));
        if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [11:0] pix_rgb(input int i);
    return 12'(i * 37 + 5);
  endfunction

  // Drive one beat for one cycle; optionally record the expected write.
  task automatic send_beat(input int x, input int y, input logic [11:0] rgb,
                           input bit expect_wr, input int exp_cyc);
    exp_t e;
    x_in = 11'(x);
    y_in = 11'(y);
    {r_in, g_in, b_in} = rgb;
    rgb_valid_in = 1'b1;
    if (expect_wr) begin
      e.addr = AW'(y * H + x);
      e.rgb  = rgb;
      e.cyc  = exp_cyc;
      sb_q.push_back(e);
    end
    tick();
    rgb_valid_in = 1'b0;
  endtask

  // Beats sampled at the next edge are written one cycle later (ready=1).
  task automatic raster(input int first, input int last);
    for (int i = first; i <= last; i++)
      send_beat(i % H, i / H, pix_rgb(i), 1'b1, cyc + 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic pulse_start();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  // Last beat's write is in progress: expect DONE next cycle, then IDLE.
  task automatic check_frame_end(input string name, input int exp_done);
    check({name, "_busy_last"}, 32'(busy_out), 32'd1);
    check({name, "_done_early"}, 32'(frame_done_out), 32'd0);
    tick();
    check({name, "_done"}, 32'(frame_done_out), 32'd1);
    check({name, "_busy_done"}, 32'(busy_out), 32'd0);
    tick();
    check({name, "_done_1cyc"}, 32'(frame_done_out), 32'd0);
    check({name, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_we",   32'(fb_we_out), 32'd0);
    check("rst_addr", 32'(fb_addr_out), 32'd0);
    check("rst_data", 32'(fb_data_out), 32'd0);
    check("rst_done", 32'(frame_done_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ovf",  32'(overflow_out), 32'd0);
    check("rst_oob",  32'(oob_out), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
    check("rst_bank", 32'(fb_bank_out), 32'd0);
    check("rst_disp", 32'(disp_bank_out), 32'd1);
`endif
    rst_in = 1'b1;
    tick();

    // ---------------- 1: four red pixels on row 0 ----------------
    fb_ready_in = 1'b1;
    pulse_start();
    check("t1_busy", 32'(busy_out), 32'd1);
    for (int i = 0; i < 4; i++) send_beat(i, 0, 12'hF00, 1'b1, cyc + 1);
    wait_drain("t1", 10);
    check("t1_hold_addr", 32'(fb_addr_out), 32'd3);
    check("t1_hold_data", 32'(fb_data_out), 32'hF00);

    // ---------------- 2: finish the raster -> frame_done ----------------
    raster(4, FPIX - 1);
    check_frame_end("t2", 1);
    wait_drain("t2", 5);
`ifdef FB_DOUBLE_BUFFER_EN
    check("t2_bank", 32'(fb_bank_out), 32'd1);
    check("t2_disp", 32'(disp_bank_out), 32'd0);
`endif

    // ---------------- 4: beat while idle, then out-of-range beat --------
    send_beat(1, 1, 12'h123, 1'b0, -1);
    tick();
    check("t4_idle_oob", 32'(oob_out), 32'd0);
    check("t4_idle_ovf", 32'(overflow_out), 32'd0);
    pulse_start();
    send_beat(H, 0, 12'h0F0, 1'b0, -1);
    check("t4_oob_x", 32'(oob_out), 32'd1);
    check("t4_oob_we", 32'(fb_we_out), 32'd0);
    send_beat(0, V, 12'h00F, 1'b0, -1);
    check("t4_oob_ovf", 32'(overflow_out), 32'd0);

    // ---------------- 3: 20 beats while the port is withheld -----------
    fb_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_beat(i % H, i / H, pix_rgb(100 + i), (i < DEP), -1);
      if (i == DEP - 1) check("t3_no_ovf_yet", 32'(overflow_out), 32'd0);
    end
    check("t3_ovf", 32'(overflow_out), 32'd1);
    check("t3_we_blocked", 32'(fb_we_out), 32'd0);
    // A start pulse while running must be ignored (no flush of the queue).
    pulse_start();
    fb_ready_in = 1'b1;
    wait_drain("t3", 40);
    tick();
    check("t3_idle_we", 32'(fb_we_out), 32'd0);
    check("t3_busy", 32'(busy_out), 32'd1);

    // ---------------- 5: reset with 5 entries queued ----------------
    fb_ready_in = 1'b0;
    for (int i = 16; i < 21; i++) send_beat(i % H, i / H, pix_rgb(i), 1'b0, -1);
    rst_in = 1'b0;
    tick();
    fb_ready_in = 1'b1;
    check("t5_we",   32'(fb_we_out), 32'd0);
    check("t5_busy", 32'(busy_out), 32'd0);
    check("t5_ovf",  32'(overflow_out), 32'd0);
    check("t5_oob",  32'(oob_out), 32'd0);
    rst_in = 1'b1;
    tick();
    tick();
    check("t5_we_after", 32'(fb_we_out), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
    check("t5_bank_rst", 32'(fb_bank_out), 32'd0);
`endif
    pulse_start();
    raster(0, FPIX - 1);
    check_frame_end("t5", 2);
    wait_drain("t5", 5);
`ifdef FB_DOUBLE_BUFFER_EN
    check("t5_bank", 32'(fb_bank_out), 32'd1);
    check("t5_disp", 32'(disp_bank_out), 32'd0);
`endif

    // ---------------- 6: another frame, bank swaps back ----------------
    pulse_start();
    raster(0, FPIX - 1);
    check_frame_end("t6", 3);
    wait_drain("t6", 5);
`ifdef FB_DOUBLE_BUFFER_EN
    check("t6_bank", 32'(fb_bank_out), 32'd0);
    check("t6_disp", 32'(disp_bank_out), 32'd1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
